// File: rtl/wb_merge_buffer.sv
// wb_merge_buffer
//   Write-back merge buffer between the two MSI caches and main memory.
//   Four single-cycle write-back sources each own one slot (valid/addr/data).
//   Pending slots drain round-robin, one per cycle, onto a single valid/ready
//   memory write port. Writes to an address already pending in the source's
//   own slot coalesce. A newer write invalidates an older pending copy of the
//   same address in another slot.
//
//   Optional feature macro: WBUF_FWD_EN
//     defined   : combinational read forwarding from pending slots
//     undefined : fwd_hit*/fwd_data* tied to zero, no compare logic
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   wb_valid[3:0]        strobes: 0 cache0-cpu, 1 cache0-bus, 2 cache1-cpu, 3 cache1-bus
//   wb_addr, wb_data     per-source address/data, source i at [i*W +: W]
//   mem_we/addr/data     memory write request (valid)
//   mem_ready            memory accepts when mem_we && mem_ready
//   busy                 any slot pending
//   overflow[3:0]        sticky per-source drop flag, cleared only by reset
//   rd_addr1/2           cache miss read addresses
//   fwd_hit1/2, fwd_data1/2  pending-write match for rd_addrN
//
// Handshake: mem_we is valid; a write transfers on a rising edge where
// mem_we && mem_ready. While mem_ready is low, mem_addr/mem_data hold.
module wb_merge_buffer #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            wb_valid,
    input  logic [4*ADDR_W-1:0]   wb_addr,
    input  logic [4*DATA_W-1:0]   wb_data,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_data,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic [3:0]            overflow,
    input  logic [ADDR_W-1:0]     rd_addr1,
    input  logic [ADDR_W-1:0]     rd_addr2,
    output logic                  fwd_hit1,
    output logic                  fwd_hit2,
    output logic [DATA_W-1:0]     fwd_data1,
    output logic [DATA_W-1:0]     fwd_data2
);

    logic [3:0]        slot_valid;
    logic [ADDR_W-1:0] slot_addr [4];
    logic [DATA_W-1:0] slot_data [4];
    logic [1:0]        rr;

    logic [ADDR_W-1:0] src_addr [4];
    logic [DATA_W-1:0] src_data [4];

    logic [1:0] sel;
    logic       any_valid;
    logic       drain;
    logic [3:0] draining;
    logic [3:0] fits;
    logic [3:0] shadowed;
    logic [3:0] accept;
    logic [3:0] drop;
    logic [3:0] kill;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            src_addr[i] = wb_addr[i*ADDR_W +: ADDR_W];
            src_data[i] = wb_data[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin pick: walk offsets from the largest down so the smallest
    // offset from rr that holds a valid slot is the final assignment.
    always_comb begin
        sel       = rr;
        any_valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (slot_valid[rr + 2'(k)]) begin
                sel       = rr + 2'(k);
                any_valid = 1'b1;
            end
        end
    end

    assign mem_we   = any_valid;
    assign busy     = any_valid;
    assign mem_addr = any_valid ? slot_addr[sel] : '0;
    assign mem_data = any_valid ? slot_data[sel] : '0;
    assign drain    = any_valid & mem_ready;

    always_comb begin
        draining = '0;
        fits     = '0;
        shadowed = '0;
        kill     = '0;
        for (int i = 0; i < 4; i++) begin
            draining[i] = drain && (sel == 2'(i));
        end
        // A source fits if its own slot is free, leaving this edge, or
        // already holds the same address (coalesce).
        for (int i = 0; i < 4; i++) begin
            fits[i] = wb_valid[i] && (!slot_valid[i] || draining[i] ||
                                      (slot_addr[i] == src_addr[i]));
        end
        // Same-cycle writes to one address: the lowest fitting index wins,
        // higher ones are dropped without raising overflow.
        for (int i = 1; i < 4; i++) begin
            for (int k = 0; k < i; k++) begin
                if (fits[k] && wb_valid[i] && (src_addr[k] == src_addr[i]))
                    shadowed[i] = 1'b1;
            end
        end
        accept = fits & ~shadowed;
        drop   = wb_valid & ~fits & ~shadowed;
        // Newer wins: an older copy in another slot is discarded unless it
        // is being written to memory on this very edge.
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                if (i != j && accept[i] && slot_valid[j] && !draining[j] &&
                    (slot_addr[j] == src_addr[i]))
                    kill[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
            overflow   <= '0;
            rr         <= '0;
            for (int j = 0; j < 4; j++) begin
                slot_addr[j] <= '0;
                slot_data[j] <= '0;
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (accept[j]) begin
                    slot_valid[j] <= 1'b1;
                    slot_addr[j]  <= src_addr[j];
                    slot_data[j]  <= src_data[j];
                end else if (draining[j] || kill[j]) begin
                    slot_valid[j] <= 1'b0;
                end
            end
            overflow <= overflow | drop;
            if (drain)
                rr <= sel + 2'd1;
        end
    end

`ifdef WBUF_FWD_EN
    // At most one slot can hold a given address, so OR-merging is exact.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int j = 0; j < 4; j++) begin
            if (slot_valid[j] && (slot_addr[j] == rd_addr1)) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = fwd_data1 | slot_data[j];
            end
            if (slot_valid[j] && (slot_addr[j] == rd_addr2)) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = fwd_data2 | slot_data[j];
            end
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^{rd_addr1, rd_addr2};
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_wb_merge_buffer.sv
module tb_wb_merge_buffer;
    localparam int AW = 9;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      wb_valid;
    logic [4*AW-1:0] wb_addr;
    logic [4*DW-1:0] wb_data;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data;
    logic            mem_ready;
    logic            busy;
    logic [3:0]      overflow;
    logic [AW-1:0]   rd_addr1, rd_addr2;
    logic            fwd_hit1, fwd_hit2;
    logic [DW-1:0]   fwd_data1, fwd_data2;

    int total = 0;
    int bad   = 0;
    logic [AW+DW-1:0] exp_q[$];

`ifdef WBUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    wb_merge_buffer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .wb_data(wb_data), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_ready(mem_ready), .busy(busy),
        .overflow(overflow), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        wb_valid  = '0;
        wb_addr   = '0;
        wb_data   = '0;
        mem_ready = 1'b0;
        rd_addr1  = '0;
        rd_addr2  = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_valid[i]        = 1'b1;
        wb_addr[i*AW +: AW] = a;
        wb_data[i*DW +: DW] = d;
    endtask

    task automatic clear_strobes();
        wb_valid = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; wb_valid = '0; wb_addr = '0; wb_data = '0;
        mem_ready = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b want=0", mem_we); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_addr); end
        total++; if (mem_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", mem_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (overflow !== 4'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0000", overflow); end
        total++; if ({fwd_hit1, fwd_hit2, fwd_data1, fwd_data2} !== '0) begin
            bad++; $display("FAIL reset_fwd got=%0b%0b %h %h want=all 0", fwd_hit1, fwd_hit2, fwd_data1, fwd_data2);
        end
        tick(); tick();
        rst_n = 1'b1;
        // pending write, then reset mid-cycle: mem_we must fall immediately
        set_src(1, 9'h0C3, 16'h5A5A);
        tick();
        clear_strobes();
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%0b want=1", mem_we); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (mem_we !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_async we=%0b busy=%0b want=0 0", mem_we, busy);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        mem_ready = 1'b1;
        set_src(0, 9'h05A, 16'hBEEF);
        tick();
        clear_strobes();
        total++; if (mem_we !== 1'b1 || mem_addr !== 9'h05A || mem_data !== 16'hBEEF) begin
            bad++; $display("FAIL single_out got we=%0b a=%h d=%h want 1 05a beef", mem_we, mem_addr, mem_data);
        end
        tick();
        total++; if (busy !== 1'b0 || mem_we !== 1'b0) begin
            bad++; $display("FAIL single_idle busy=%0b we=%0b want 0 0", busy, mem_we);
        end
    endtask

    task automatic test_four();
        logic [AW-1:0] ea;
        apply_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_src(i, 9'h010 + AW'(i), 16'hA000 + DW'(i));
        tick();
        clear_strobes();
        for (int k = 0; k < 4; k++) begin
            ea = 9'h010 + AW'(k);
            total++; if (mem_we !== 1'b1 || mem_addr !== ea || mem_data !== 16'hA000 + DW'(k)) begin
                bad++; $display("FAIL four_order k=%0d got we=%0b a=%h d=%h want a=%h", k, mem_we, mem_addr, mem_data, ea);
            end
            tick();
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL four_idle busy=%0b want 0", busy); end
        // rr back at 0: slot 0 must be served before slot 3
        set_src(3, 9'h0A0, 16'h3333);
        set_src(0, 9'h0B0, 16'h0000);
        tick();
        clear_strobes();
        total++; if (mem_addr !== 9'h0B0) begin bad++; $display("FAIL four_rr0 got=%h want=0b0", mem_addr); end
        tick();
        total++; if (mem_addr !== 9'h0A0) begin bad++; $display("FAIL four_rr1 got=%h want=0a0", mem_addr); end
        tick();
    endtask

    task automatic test_coalesce();
        int writes;
        apply_reset();
        set_src(0, 9'h020, 16'h1111);
        tick();
        clear_strobes();
        total++; if (mem_addr !== 9'h020 || mem_data !== 16'h1111) begin
            bad++; $display("FAIL dedup_first got a=%h d=%h want 020 1111", mem_addr, mem_data);
        end
        set_src(2, 9'h020, 16'h2222);
        tick();
        clear_strobes();
        total++; if (mem_addr !== 9'h020 || mem_data !== 16'h2222) begin
            bad++; $display("FAIL dedup_newer got a=%h d=%h want 020 2222", mem_addr, mem_data);
        end
        mem_ready = 1'b1;
        writes = 0;
        for (int c = 0; c < 5; c++) begin
            if (mem_we) begin
                writes++;
                total++; if (mem_data !== 16'h2222) begin bad++; $display("FAIL dedup_data got=%h want=2222", mem_data); end
            end
            tick();
        end
        total++; if (writes != 1) begin bad++; $display("FAIL dedup_count got=%0d want=1", writes); end
    endtask

    task automatic test_overflow();
        int writes;
        apply_reset();
        set_src(1, 9'h030, 16'h3030);
        tick();
        set_src(1, 9'h031, 16'h3131);
        tick();
        clear_strobes();
        total++; if (overflow !== 4'b0010) begin bad++; $display("FAIL ovf_flag got=%b want=0010", overflow); end
        mem_ready = 1'b1;
        writes = 0;
        for (int c = 0; c < 4; c++) begin
            if (mem_we) begin
                writes++;
                total++; if (mem_addr !== 9'h030 || mem_data !== 16'h3030) begin
                    bad++; $display("FAIL ovf_write got a=%h d=%h want 030 3030", mem_addr, mem_data);
                end
            end
            tick();
        end
        total++; if (writes != 1) begin bad++; $display("FAIL ovf_count got=%0d want=1", writes); end
        total++; if (overflow !== 4'b0010) begin bad++; $display("FAIL ovf_sticky got=%b want=0010", overflow); end
        apply_reset();
        total++; if (overflow !== 4'b0000) begin bad++; $display("FAIL ovf_clear got=%b want=0000", overflow); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        set_src(1, 9'h041, 16'h4141);
        set_src(3, 9'h043, 16'h4343);
        tick();
        clear_strobes();
        for (int c = 0; c < 3; c++) begin
            total++; if (mem_we !== 1'b1 || mem_addr !== 9'h041) begin
                bad++; $display("FAIL bp_hold c=%0d we=%0b a=%h want 1 041", c, mem_we, mem_addr);
            end
            tick();
        end
        mem_ready = 1'b1;
        total++; if (mem_addr !== 9'h041) begin bad++; $display("FAIL bp_first got=%h want=041", mem_addr); end
        tick();
        total++; if (mem_addr !== 9'h043 || mem_data !== 16'h4343) begin
            bad++; $display("FAIL bp_second got a=%h d=%h want 043 4343", mem_addr, mem_data);
        end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle busy=%0b want 0", busy); end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        set_src(0, 9'h060, 16'h1234);
        set_src(2, 9'h060, 16'h5678);
        tick();
        clear_strobes();
        total++; if (mem_addr !== 9'h060 || mem_data !== 16'h1234 || overflow !== 4'b0) begin
            bad++; $display("FAIL tie_low a=%h d=%h ovf=%b want 060 1234 0000", mem_addr, mem_data, overflow);
        end
        mem_ready = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL tie_single busy=%0b want 0", busy); end
        // slot draining at the same edge a newer copy arrives: both are written
        mem_ready = 1'b0;
        set_src(0, 9'h070, 16'hAAAA);
        tick();
        clear_strobes();
        mem_ready = 1'b1;
        set_src(1, 9'h070, 16'hBBBB);
        tick();
        clear_strobes();
        total++; if (mem_we !== 1'b1 || mem_addr !== 9'h070 || mem_data !== 16'hBBBB) begin
            bad++; $display("FAIL drain_follow we=%0b a=%h d=%h want 1 070 bbbb", mem_we, mem_addr, mem_data);
        end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_idle busy=%0b want 0", busy); end
    endtask

    task automatic test_forward();
        apply_reset();
        set_src(3, 9'h1FF, 16'hCAFE);
        tick();
        clear_strobes();
        rd_addr1 = 9'h1FF;
        rd_addr2 = 9'h000;
        #1;
        total++; if (fwd_hit1 !== FWD || fwd_data1 !== (FWD ? 16'hCAFE : 16'h0)) begin
            bad++; $display("FAIL fwd1 hit=%0b d=%h want %0b", fwd_hit1, fwd_data1, FWD);
        end
        total++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 16'h0) begin
            bad++; $display("FAIL fwd2 hit=%0b d=%h want 0 0", fwd_hit2, fwd_data2);
        end
        mem_ready = 1'b1;  // slot is draining this cycle but still forwards
        #1;
        total++; if (fwd_hit1 !== FWD) begin bad++; $display("FAIL fwd_drain hit=%0b want %0b", fwd_hit1, FWD); end
        tick();
        total++; if (fwd_hit1 !== 1'b0) begin bad++; $display("FAIL fwd_gone hit=%0b want 0", fwd_hit1); end
    endtask

    // Reference: each source owns one pending entry; the oldest-in-rotation
    // entry is offered to memory; writes follow the accept/coalesce/drop
    // and newer-wins rules.
    task automatic test_random();
        bit            mv [4];
        logic [AW-1:0] ma [4];
        logic [DW-1:0] md [4];
        int            m_rr;
        logic [3:0]    m_ovf;
        int            m_sel;
        bit            m_any, drn;
        bit            fit [4];
        bit            acc [4];
        bit            nv  [4];
        bit            eh1, eh2;
        logic [DW-1:0] ed1, ed2;
        logic [AW+DW-1:0] got;
        logic [AW-1:0] a_in [4];

        apply_reset();
        for (int j = 0; j < 4; j++) begin mv[j] = 0; ma[j] = '0; md[j] = '0; end
        m_rr = 0; m_ovf = '0;
        exp_q.delete();

        for (int n = 0; n < 420; n++) begin
            wb_valid = '0;
            if (n < 400) begin
                for (int i = 0; i < 4; i++) begin
                    if ($urandom_range(0, 7) < 3) set_src(i, 9'h100 + AW'($urandom_range(0, 5)), DW'($urandom));
                end
                mem_ready = ($urandom_range(0, 9) < 7);
            end else begin
                mem_ready = 1'b1;
            end
            rd_addr1 = 9'h100 + AW'($urandom_range(0, 7));
            rd_addr2 = 9'h100 + AW'($urandom_range(0, 7));
            #1;
            m_any = 0; m_sel = 0;
            for (int k = 0; k < 4; k++) begin
                if (!m_any && mv[(m_rr + k) % 4]) begin m_any = 1; m_sel = (m_rr + k) % 4; end
            end
            total++; if (mem_we !== m_any || busy !== m_any) begin
                bad++; $display("FAIL rnd_we n=%0d we=%0b busy=%0b want=%0b", n, mem_we, busy, m_any);
            end
            total++; if (mem_addr !== (m_any ? ma[m_sel] : '0) || mem_data !== (m_any ? md[m_sel] : '0)) begin
                bad++; $display("FAIL rnd_out n=%0d a=%h d=%h want a=%h d=%h", n, mem_addr, mem_data,
                                m_any ? ma[m_sel] : '0, m_any ? md[m_sel] : '0);
            end
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf n=%0d got=%b want=%b", n, overflow, m_ovf); end
            eh1 = 0; eh2 = 0; ed1 = '0; ed2 = '0;
            for (int j = 0; j < 4; j++) begin
                if (FWD && mv[j] && ma[j] == rd_addr1) begin eh1 = 1; ed1 = md[j]; end
                if (FWD && mv[j] && ma[j] == rd_addr2) begin eh2 = 1; ed2 = md[j]; end
            end
            total++; if (fwd_hit1 !== eh1 || fwd_data1 !== ed1 || fwd_hit2 !== eh2 || fwd_data2 !== ed2) begin
                bad++; $display("FAIL rnd_fwd n=%0d got %0b %h %0b %h want %0b %h %0b %h", n,
                                fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, eh1, ed1, eh2, ed2);
            end
            // scoreboard of completed memory writes
            drn = m_any && mem_ready;
            if (drn) exp_q.push_back({ma[m_sel], md[m_sel]});
            if (mem_we && mem_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rnd_sb_extra n=%0d a=%h d=%h want none", n, mem_addr, mem_data);
                end else begin
                    got = exp_q.pop_front();
                    if ({mem_addr, mem_data} !== got) begin
                        bad++; $display("FAIL rnd_sb n=%0d got=%h want=%h", n, {mem_addr, mem_data}, got);
                    end
                end
            end
            // advance the reference
            for (int i = 0; i < 4; i++) a_in[i] = wb_addr[i*AW +: AW];
            for (int i = 0; i < 4; i++) begin
                fit[i] = wb_valid[i] && (!mv[i] || (drn && m_sel == i) || ma[i] == a_in[i]);
            end
            for (int i = 0; i < 4; i++) begin
                bit lost_tie;
                lost_tie = 0;
                for (int k = 0; k < i; k++) if (fit[k] && a_in[k] == a_in[i]) lost_tie = 1;
                acc[i] = fit[i] && !lost_tie;
                if (wb_valid[i] && !fit[i] && !lost_tie) m_ovf[i] = 1'b1;
            end
            for (int j = 0; j < 4; j++) nv[j] = mv[j];
            if (drn) nv[m_sel] = 0;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    for (int j = 0; j < 4; j++) begin
                        if (j != i && mv[j] && !(drn && m_sel == j) && ma[j] == a_in[i]) nv[j] = 0;
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin nv[i] = 1; ma[i] = a_in[i]; md[i] = wb_data[i*DW +: DW]; end
            end
            for (int j = 0; j < 4; j++) mv[j] = nv[j];
            if (drn) m_rr = (m_sel + 1) % 4;
            tick();
        end
        clear_strobes();
        total++; if (exp_q.size() != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL rnd_drained left=%0d busy=%0b want 0 0", exp_q.size(), busy);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single();
        test_four();
        test_coalesce();
        test_overflow();
        test_backpressure();
        test_same_cycle();
        test_forward();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_merge_buffer.md
# wb_merge_buffer

Write-back merge buffer sitting between the two MSI caches and main memory. Captures the four single-cycle write-back strobes (cache 0 CPU-side, cache 0 bus-side, cache 1 CPU-side, cache 1 bus-side) into per-source slots. Drops stale duplicates and drains them one per cycle onto a single valid/ready memory write port. This replaces the four parallel write ports on the 512x16 memory.

## Interface
Parameters:
- ADDR_W, 9, write/read address width
- DATA_W, 16, data word width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wb_valid  in  4  write-back strobes; bit 0 cache0-cpu, 1 cache0-bus, 2 cache1-cpu, 3 cache1-bus; no backpressure
- wb_addr  in  4*ADDR_W  per-source address, source i at [i*ADDR_W +: ADDR_W]
- wb_data  in  4*DATA_W  per-source data, same packing
- mem_we  out  1  memory write valid
- mem_addr  out  ADDR_W  memory write address
- mem_data  out  DATA_W  memory write data
- mem_ready  in  1  memory accepts write when mem_we && mem_ready
- busy  out  1  any slot valid
- overflow  out  4  sticky per-source drop flag
- rd_addr1, rd_addr2  in  ADDR_W  cache miss read addresses (forwarding)
- fwd_hit1, fwd_hit2  out  1  pending write matches rd_addrN
- fwd_data1, fwd_data2  out  DATA_W  matched pending data

## Operation
- Four slots, slot i owned by source i: valid, addr, data. Reset clears all valid bits, overflow=0, rr pointer=0.
- Drain: round-robin over valid slots, starting at rr pointer. mem_we=1 iff any slot valid; mem_addr/mem_data come combinationally from the selected slot. On mem_we && mem_ready the selected slot clears and rr becomes the granted index+1 (mod 4). Without ready, the selection and outputs hold stable.
- Accept on wb_valid[i]:
  - slot i empty, or being drained this cycle: load addr/data, set valid.
  - slot i valid with the same addr: overwrite data (coalesce).
  - slot i valid with a different addr, not draining: drop the request, set overflow[i] (cleared only by reset).
- Newer-wins dedup: when source i is accepted with address A, every other valid slot j holding A that is not draining this cycle is invalidated at the same edge. If slot j is draining this cycle, the drain completes and the new write follows later.
- Simultaneous accepts to the same address: the lowest index wins. The other sources are dropped silently; overflow is not set.
- Invariant: at most one valid slot per address.
- Outputs at reset: mem_we=0, mem_addr=0, mem_data=0, busy=0, overflow=0, fwd_hit*=0, fwd_data*=0.

## Timing
- Strobe at edge N sets the slot at N; mem_we rises in cycle N+1. Minimum latency is 1 cycle.
- Throughput: one memory write per cycle with mem_ready held high.
- A slot freed by drain at edge N can accept a new strobe at the same edge N.
- Starvation bound: with mem_ready=1, any valid slot is issued within 4 cycles.
- Reset asserted mid-operation: all pending writes are discarded immediately and mem_we drops asynchronously.

## Configuration
- WBUF_FWD_EN defined: combinational forwarding. fwd_hitN=1 and fwd_dataN=slot data when any valid slot addr == rd_addrN; a slot draining this cycle still hits. Otherwise hit=0, data=0.
- Not defined: fwd_hit*/fwd_data* tied to 0, and no compare logic is built.

## Test plan
- Single write: wb_valid=0001, addr 0x05A, data 0xBEEF, mem_ready=1 -> next cycle mem_we=1, addr 0x05A, data 0xBEEF; the cycle after, busy=0.
- Four simultaneous writes to 0x010..0x013, mem_ready=1 -> issued in order 0,1,2,3 in four consecutive cycles; rr=0 afterwards.
- Coalesce/dedup: src0 writes 0x020=0x1111 with mem_ready=0, then src2 writes 0x020=0x2222 -> slot0 invalidated; after ready, exactly one write 0x020=0x2222.
- Overflow: mem_ready=0, src1 writes 0x030 then 0x031 -> second dropped, overflow=0010; after ready, only 0x030 written; flag persists until rst_n=0.
- Backpressure: mem_ready=0 for 3 cycles with slots 1 and 3 valid -> mem_addr stable; ready=1 -> slot1 then slot3.
- Forwarding (WBUF_FWD_EN): slot3 holds 0x1FF=0xCAFE, rd_addr1=0x1FF -> fwd_hit1=1, fwd_data1=0xCAFE; rd_addr2=0x000 -> fwd_hit2=0. Without the macro, both hits are 0.
